// File: rtl/isp_wb_gain_pkg.sv
// Shared ISP raw-domain definitions: Bayer pattern encodings, channel indices
// and the white-balance pipeline depth.
package isp_pkg;

    typedef enum logic [1:0] {
        BAYER_RGGB = 2'd0,
        BAYER_GRBG = 2'd1,
        BAYER_GBRG = 2'd2,
        BAYER_BGGR = 2'd3
    } bayer_e;

    localparam logic [1:0] CH_R  = 2'd0;
    localparam logic [1:0] CH_GR = 2'd1;
    localparam logic [1:0] CH_GB = 2'd2;
    localparam logic [1:0] CH_B  = 2'd3;

    localparam int unsigned PIPE_DELAY = 3;

    // Channel of a pixel: {row,col} parity folded through the pattern code.
    function automatic logic [1:0] bayer_channel(bayer_e pat, logic row, logic col);
        return {row, col} ^ pat;
    endfunction

endpackage

// File: rtl/isp_wb_gain_if.sv
// Raw pixel stream: line valid, frame sync and pixel data.
interface isp_wb_gain_if #(
    parameter int unsigned BITS = 8
) ();
    logic            href;
    logic            vsync;
    logic [BITS-1:0] raw;

    modport master (output href, vsync, raw);
    modport slave  (input  href, vsync, raw);
endinterface

// File: rtl/isp_wb_gain_bayer_pos.sv
// Raw-stream position tracker: col/row parity and frame-start pulse,
// shared by white balance, demosaic and AWB statistics.
module isp_bayer_pos (
    input  logic pclk,
    input  logic rst_n,
    input  logic href_i,
    input  logic vsync_i,
    output logic col_o,
    output logic row_o,
    output logic frame_start_o
);

    logic vsync_q, href_q, col_q, row_q;
    logic col_d, row_d;
    logic frame_start;

    assign frame_start = vsync_i & ~vsync_q;

    always_comb begin
        col_d = href_i ? ~col_q : 1'b0;
        row_d = row_q;
        // Frame start wins over a coincident href falling edge.
        if (frame_start) begin
            row_d = 1'b0;
        end else if (href_q && !href_i) begin
            row_d = ~row_q;
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            col_q   <= 1'b0;
            row_q   <= 1'b0;
        end else begin
            vsync_q <= vsync_i;
            href_q  <= href_i;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end

    assign col_o         = col_q;
    assign row_o         = frame_start ? 1'b0 : row_q;
    assign frame_start_o = frame_start;

endmodule

// File: rtl/isp_wb_gain.sv
// Bayer black-level subtract + per-channel digital gain with round/saturate.
// Configuration is shadowed and only taken on the frame-start edge.
module isp_wb_gain
    import isp_pkg::*;
#(
    parameter int unsigned BITS      = 8,
    parameter int unsigned GAIN_BITS = 8,
    parameter int unsigned GAIN_FRAC = 4
) (
    input  logic                 pclk,
    input  logic                 rst_n,
    input  logic                 enable_i,
    input  logic [1:0]           bayer_i,
    input  logic [BITS-1:0]      blc_i,
    input  logic [GAIN_BITS-1:0] r_gain_i,
    input  logic [GAIN_BITS-1:0] gr_gain_i,
    input  logic [GAIN_BITS-1:0] gb_gain_i,
    input  logic [GAIN_BITS-1:0] b_gain_i,
    isp_wb_gain_if.slave         in_if,
    isp_wb_gain_if.master        out_if
);

    localparam int unsigned         PW       = BITS + GAIN_BITS;
    localparam logic [BITS-1:0]     PIX_MAX  = '1;
    localparam logic [GAIN_BITS-1:0] UNITY   = GAIN_BITS'(1 << GAIN_FRAC);

    logic col, row, frame_start;

    isp_bayer_pos u_pos (
        .pclk          (pclk),
        .rst_n         (rst_n),
        .href_i        (in_if.href),
        .vsync_i       (in_if.vsync),
        .col_o         (col),
        .row_o         (row),
        .frame_start_o (frame_start)
    );

    // Shadow configuration
    logic                 en_q, en_d;
    bayer_e               bayer_q, bayer_d;
    logic [BITS-1:0]      blc_q, blc_d;
    logic [GAIN_BITS-1:0] gain_q [4];
    logic [GAIN_BITS-1:0] gain_d [4];

    // The _d values feed stage 1 so the edge-cycle pixel sees the new config.
    always_comb begin
        en_d    = en_q;
        bayer_d = bayer_q;
        blc_d   = blc_q;
        gain_d  = gain_q;
        if (frame_start) begin
            en_d          = enable_i;
            bayer_d       = bayer_e'(bayer_i);
            blc_d         = blc_i;
            gain_d[CH_R]  = r_gain_i;
            gain_d[CH_GR] = gr_gain_i;
            gain_d[CH_GB] = gb_gain_i;
            gain_d[CH_B]  = b_gain_i;
        end
    end

    // Pipeline datapath
    logic [1:0]           idx;
    logic [BITS-1:0]      d1_q, d1_d, raw1_q, raw2_q, raw3_q, raw3_d;
    logic [GAIN_BITS-1:0] g1_q;
    logic                 en1_q, en2_q;
    logic [PW-1:0]        p2_q, p2_d;
    logic [PW:0]          rnd;
    logic [1:0]           sb_q [PIPE_DELAY];

    always_comb begin
        idx  = bayer_channel(bayer_d, row, col);
        d1_d = (in_if.raw > blc_d) ? (in_if.raw - blc_d) : '0;
        p2_d = PW'(d1_q) * PW'(g1_q);
    end

    // One guard bit above the product keeps the rounding add from wrapping.
    if (GAIN_FRAC > 0) begin : g_round
        assign rnd = ({1'b0, p2_q} + ((PW + 1)'(1) << (GAIN_FRAC - 1))) >> GAIN_FRAC;
    end else begin : g_noround
        assign rnd = {1'b0, p2_q};
    end

    always_comb begin
        raw3_d = '0;
        if (sb_q[PIPE_DELAY-2][1]) begin
            if (!en2_q) begin
                raw3_d = raw2_q;
            end else if (rnd > (PW + 1)'(PIX_MAX)) begin
                raw3_d = PIX_MAX;
            end else begin
                raw3_d = rnd[BITS-1:0];
            end
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            en_q    <= 1'b0;
            bayer_q <= BAYER_RGGB;
            blc_q   <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                gain_q[i] <= UNITY;
            end
            d1_q   <= '0;
            g1_q   <= '0;
            en1_q  <= 1'b0;
            raw1_q <= '0;
            p2_q   <= '0;
            en2_q  <= 1'b0;
            raw2_q <= '0;
            raw3_q <= '0;
            for (int unsigned i = 0; i < PIPE_DELAY; i++) begin
                sb_q[i] <= '0;
            end
        end else begin
            en_q    <= en_d;
            bayer_q <= bayer_d;
            blc_q   <= blc_d;
            gain_q  <= gain_d;
            d1_q    <= d1_d;
            g1_q    <= gain_d[idx];
            en1_q   <= en_d;
            raw1_q  <= in_if.raw;
            p2_q    <= p2_d;
            en2_q   <= en1_q;
            raw2_q  <= raw1_q;
            raw3_q  <= raw3_d;
            sb_q[0] <= {in_if.href, in_if.vsync};
            for (int unsigned i = 1; i < PIPE_DELAY; i++) begin
                sb_q[i] <= sb_q[i-1];
            end
        end
    end

    assign out_if.href  = sb_q[PIPE_DELAY-1][1];
    assign out_if.vsync = sb_q[PIPE_DELAY-1][0];
    assign out_if.raw   = raw3_q;

endmodule
